// File: rtl/packet_deconstructor.sv
// ---------------------------------------------------------------------------
// packet_deconstructor
//
// Splits a sentinel-terminated UART byte stream into packet beats. One byte
// of lookahead sits in a holding register. Only a later byte or the sentinel
// shows whether the held byte is the last byte of its packet. An empty packet
// (a sentinel with nothing held) is dropped.
//
// Optional feature: define PACKET_DECONSTRUCTOR_STATS_EN to add the
// packet_count output. It is a 16-bit wrapping count of delivered packets.
//
// Ports
//   clock         in   sole clock, rising edge
//   reset         in   asynchronous, active-high reset
//   uart_data     in   [7:0] received UART byte
//   uart_valid    in   uart_data valid this cycle
//   uart_ready    out  block accepts uart_data this cycle
//   packet_data   out  [7:0] payload byte (registered)
//   packet_valid  out  packet_data valid (registered)
//   packet_ready  in   downstream accepts the beat
//   packet_last   out  final payload byte of a packet (registered)
//   packet_count  out  [15:0] completed packets (STATS_EN builds only)
// ---------------------------------------------------------------------------
module packet_deconstructor #(
  parameter logic [7:0] SENTINEL = 8'h00
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  uart_data,
  input  logic        uart_valid,
  output logic        uart_ready,
  output logic [7:0]  packet_data,
  output logic        packet_valid,
  input  logic        packet_ready,
  output logic        packet_last
`ifdef PACKET_DECONSTRUCTOR_STATS_EN
  ,
  output logic [15:0] packet_count
`endif
);

  // EMPTY means no byte is held; HELD means hold_data_q holds a byte.
  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  hold_data_q, hold_data_d;
  logic [7:0]  packet_data_q, packet_data_d;
  logic        packet_valid_q, packet_valid_d;
  logic        packet_last_q, packet_last_d;

  logic        accept;
  logic        consume;
  logic        is_sentinel;

  // A new byte may be accepted only when the output register is free now or
  // is drained this cycle. A load can then never overwrite a stalled beat.
  assign uart_ready  = ~packet_valid_q | packet_ready;
  assign accept      = uart_valid & uart_ready;
  assign consume     = packet_valid_q & packet_ready;
  assign is_sentinel = (uart_data == SENTINEL);

  // Next-state and datapath. When a beat drains and a load happens in the
  // same cycle, the load wins, so the stream runs with no bubble.
  always_comb begin
    state_d        = state_q;
    hold_data_d    = hold_data_q;
    packet_data_d  = packet_data_q;
    packet_valid_d = packet_valid_q;
    packet_last_d  = packet_last_q;

    if (consume) begin
      packet_valid_d = 1'b0;
    end

    if (accept) begin
      unique case (state_q)
        EMPTY: begin
          if (!is_sentinel) begin
            hold_data_d = uart_data;
            state_d     = HELD;
          end
        end
        HELD: begin
          packet_data_d  = hold_data_q;
          packet_valid_d = 1'b1;
          packet_last_d  = is_sentinel;
          if (is_sentinel) begin
            state_d = EMPTY;
          end else begin
            hold_data_d = uart_data;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= EMPTY;
      hold_data_q    <= 8'h00;
      packet_data_q  <= 8'h00;
      packet_valid_q <= 1'b0;
      packet_last_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      hold_data_q    <= hold_data_d;
      packet_data_q  <= packet_data_d;
      packet_valid_q <= packet_valid_d;
      packet_last_q  <= packet_last_d;
    end
  end

  assign packet_data  = packet_data_q;
  assign packet_valid = packet_valid_q;
  assign packet_last  = packet_last_q;

`ifdef PACKET_DECONSTRUCTOR_STATS_EN
  logic [15:0] packet_count_q, packet_count_d;

  // A packet counts when its last beat is delivered, not when it is loaded.
  // The count wraps from 16'hFFFF to 0.
  always_comb begin
    packet_count_d = packet_count_q;
    if (consume && packet_last_q) begin
      packet_count_d = packet_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      packet_count_q <= 16'h0000;
    end else begin
      packet_count_q <= packet_count_d;
    end
  end

  assign packet_count = packet_count_q;
`endif

endmodule
